// File: rtl/sinpix_tt_sweeper.sv
// sinpix_tt_sweeper: drives every input code onto a single-output network and packs the sampled
// outputs into a truth-table word with a popcount, handed off over valid/ready.
module sinpix_tt_sweeper #(
  parameter int NIN  = 6,
  parameter int LAT  = 1,
  parameter int TT_W = 2**NIN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [NIN-1:0]  x_out,
  input  logic            y_in,
  output logic            busy,
  output logic [TT_W-1:0] tt_out,
  output logic [NIN:0]    ones_cnt,
  output logic            tt_valid,
  input  logic            tt_ready
);
  localparam int CW = $clog2(LAT) + 1;
  localparam logic [CW-1:0]  HOLD_END = CW'(LAT - 1);
  localparam logic [NIN-1:0] X_END    = NIN'(TT_W - 1);
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  state_t          state_q, state_d;
  logic [NIN-1:0]  x_q, x_d;
  logic [TT_W-1:0] tt_q, tt_d;
  logic [NIN:0]    ones_q, ones_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d, valid_q, valid_d, sample, last;
  assign sample = (state_q == SWEEP) && (cnt_q == HOLD_END);
  assign last   = x_q == X_END;
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    tt_d    = tt_q;
    ones_d  = ones_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = IDLE;
      x_d     = '0;
      tt_d    = '0;
      ones_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = SWEEP;
          x_d     = '0;
          tt_d    = '0;
          ones_d  = '0;
          cnt_d   = '0;
        end
        SWEEP: if (sample) begin
          tt_d[x_q] = y_in;
          ones_d    = ones_q + (NIN+1)'(y_in);
          cnt_d     = '0;
          x_d       = last ? '0 : x_q + 1'b1;
          state_d   = last ? DONE : SWEEP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        DONE: state_d = tt_ready ? IDLE : DONE;
        default: state_d = IDLE;
      endcase
    end
  end
  // Status flags are registered from the next state so they change on the same edge as state.
  assign busy_d  = state_d != IDLE;
  assign valid_d = state_d == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      tt_q    <= '0;
      ones_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      tt_q    <= tt_d;
      ones_q  <= ones_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end
  assign x_out    = x_q;
  assign tt_out   = tt_q;
  assign ones_cnt = ones_q;
  assign busy     = busy_q;
  assign tt_valid = valid_q;
endmodule

// File: tb/tb_sinpix_tt_sweeper.sv
// tb_sinpix_tt_sweeper: random and directed sweeps of LAT=1 and LAT=3 instances against a
// truth-table reference model; the network is modelled as a 64-entry lookup table.
module tb_sinpix_tt_sweeper;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  start, abort, rdy;
  logic [63:0] tab;
  logic        sel;
  logic [5:0]  x1, x3, xs;
  logic        b1, b3, bs, v1, v3, vs;
  logic [63:0] t1, t3, ts;
  logic [6:0]  o1, o3, os;
  int          n_tests = 0;
  int          n_fail = 0;
  always #5 clk = ~clk;
  sinpix_tt_sweeper #(.NIN(6), .LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .x_out(x1), .y_in(tab[x1]),
    .busy(b1), .tt_out(t1), .ones_cnt(o1), .tt_valid(v1), .tt_ready(rdy[0])
  );
  sinpix_tt_sweeper #(.NIN(6), .LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .x_out(x3), .y_in(tab[x3]),
    .busy(b3), .tt_out(t3), .ones_cnt(o3), .tt_valid(v3), .tt_ready(rdy[1])
  );
  assign xs = sel ? x3 : x1;
  assign bs = sel ? b3 : b1;
  assign vs = sel ? v3 : v1;
  assign ts = sel ? t3 : t1;
  assign os = sel ? o3 : o1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  // sin(pi*x/64) > 1/2  <=>  64/6 < x < 5*64/6
  function automatic logic [63:0] sin_tab();
    logic [63:0] t;
    for (int k = 0; k < 64; k++) t[k] = (6 * k > 64) && (6 * k < 320);
    return t;
  endfunction
  function automatic logic [63:0] rnd_tab();
    return {$urandom(), $urandom()};
  endfunction
  task automatic idle_chk(input string tag, input logic [63:0] t);
    chk({tag, "_busy"}, 64'(bs), 64'(0));
    chk({tag, "_valid"}, 64'(vs), 64'(0));
    chk({tag, "_x"}, 64'(xs), 64'(0));
    chk({tag, "_tt"}, ts, t);
    chk({tag, "_ones"}, 64'(os), 64'($countones(t)));
  endtask
  task automatic go(input bit s);
    @(negedge clk); start[s] = 1'b1;
    @(negedge clk); start[s] = 1'b0;
  endtask
  task automatic sweep(input bit s, input int lat, input logic [63:0] t);
    int n = 64 * lat;
    tab = t; sel = s;
    go(s);
    chk("sw_x0", 64'(xs), 64'(0));
    chk("sw_busy0", 64'(bs), 64'(1));
    for (int e = 1; e <= n; e++) begin
      start[s] = 1'($urandom_range(0, 1));
      rdy[s]   = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("sw_x", 64'(xs), 64'(e < n ? (e / lat) % 64 : 0));
      chk("sw_valid", 64'(vs), 64'(e == n));
    end
    start[s] = 1'b0; rdy[s] = 1'b0;
    chk("sw_tt", ts, t);
    chk("sw_ones", 64'(os), 64'($countones(t)));
    chk("sw_busy", 64'(bs), 64'(1));
  endtask
  task automatic release_res(input bit s, input logic [63:0] t);
    @(negedge clk); rdy[s] = 1'b1;
    @(negedge clk); rdy[s] = 1'b0;
    idle_chk("rel", t);
  endtask
  initial begin
    logic [63:0] t;
    start = '0; abort = '0; rdy = '0; sel = 1'b0; tab = '0;
    repeat (3) @(negedge clk);
    idle_chk("rst1", '0);
    sel = 1'b1;
    idle_chk("rst3", '0);
    rst_n = 1'b1;
    @(negedge clk);
    // directed tables
    t = {32{2'b10}};
    sweep(0, 1, t);
    chk("t1_tt", ts, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("t1_ones", 64'(os), 64'(32));
    release_res(0, t);
    sweep(1, 3, '1);
    chk("t2_ones", 64'(os), 64'(64));
    release_res(1, '1);
    sweep(0, 1, sin_tab());
    release_res(0, sin_tab());
    sweep(1, 3, sin_tab());
    release_res(1, sin_tab());
    sweep(0, 1, '0);
    release_res(0, '0);
    for (int i = 0; i < 4; i++) begin
      t = rnd_tab();
      sweep(i % 2 == 1, (i % 2 == 1) ? 3 : 1, t);
      release_res(i % 2 == 1, t);
    end
    // backpressure with ignored start, then ready+start together
    t = rnd_tab();
    sweep(0, 1, t);
    for (int i = 0; i < 10; i++) begin
      start[0] = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("bp_valid", 64'(vs), 64'(1));
      chk("bp_tt", ts, t);
      chk("bp_ones", 64'(os), 64'($countones(t)));
    end
    start[0] = 1'b1; rdy[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0; rdy[0] = 1'b0;
    idle_chk("bp_rel", t);
    @(negedge clk);
    idle_chk("bp_noq", t);
    // abort mid-sweep at x_out=20
    tab = rnd_tab(); sel = 1'b0;
    go(0);
    for (int i = 0; i < 100 && xs != 6'd20; i++) @(negedge clk);
    chk("ab_reach20", 64'(xs), 64'(20));
    abort[0] = 1'b1; start[0] = 1'b1; rdy[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0; start[0] = 1'b0; rdy[0] = 1'b0;
    idle_chk("ab_mid", '0);
    t = rnd_tab();
    sweep(0, 1, t);
    release_res(0, t);
    // abort in DONE clears held result
    t = rnd_tab();
    sweep(1, 3, t);
    abort[1] = 1'b1;
    @(negedge clk);
    abort[1] = 1'b0;
    idle_chk("ab_done", '0);
    // asynchronous reset between edges
    tab = rnd_tab(); sel = 1'b0;
    go(0);
    repeat (10) @(negedge clk);
    chk("ar_busy_pre", 64'(bs), 64'(1));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 idle_chk("ar_now", '0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("ar_idle", 64'(bs), 64'(0));
    end
    t = rnd_tab();
    sweep(0, 1, t);
    release_res(0, t);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
